mem_access_unit: RTL

MEM-stage load/store unit for the five-stage RISC-V pipeline. It consumes the memory-control fields held in the EX/MEM pipeline register and executes each access on a single-outstanding req/ack data bus. Toward the bus it drives word-aligned address, byte enables and lane-replicated store data. Toward the pipeline it returns sign- or zero-extended load data, and it stalls the pipeline while an access is in flight.

---
 rtl/mem_access_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one access at a time on a req/ack bus, with sign/zero-extended load return.
// Stalls the pipeline from the access's IDLE cycle through its last REQ cycle; results pulse in DONE.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MemOp_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] Addr_in,
    input  logic [31:0] WriteData_in,
    output logic        stall_out,
    output logic [31:0] LoadData_out,
    output logic        LoadValid_out,
    output logic        exc_valid_out,
    output logic [1:0]  exc_code_out,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;
    localparam logic [7:0] TIMEOUT_LIM  = 8'(TIMEOUT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_inc;
    logic [1:0]  offset;
    logic [2:0]  op;

    logic        access;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;

    logic        start_bus;
    logic        exc_set;
    logic [1:0]  exc_code_nxt;
    logic        ack_ok;

    assign access  = MemRead_in | MemWrite_in;
    assign cnt_inc = cnt + 8'd1;

    assign illegal = (MemRead_in & MemWrite_in)
                   | (MemRead_in  & ((MemOp_in == 3'b011) | (MemOp_in[2:1] == 2'b11)))
                   | (MemWrite_in & (MemOp_in[2] | (MemOp_in[1:0] == 2'b11)));

    assign misaligned = ((MemOp_in[1:0] == 2'b01) & Addr_in[0])
                      | ((MemOp_in[1:0] == 2'b10) & (Addr_in[1:0] != 2'b00));

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = WriteData_in;
        case (MemOp_in[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << Addr_in[1:0];
                wdata_nxt = {4{WriteData_in[7:0]}};
            end
            2'b01: begin
                be_nxt    = Addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{WriteData_in[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = WriteData_in;
            end
        endcase
    end

    // Move the addressed byte/halfword down to bit 0 before extension.
    assign rd_shift = bus_rdata >> {offset, 3'b000};

    always_comb begin
        load_ext = rd_shift;
        case (op)
            3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_ext = {24'd0, rd_shift[7:0]};
            3'b101:  load_ext = {16'd0, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        stall_out    = 1'b0;
        bus_req      = 1'b0;
        start_bus    = 1'b0;
        exc_set      = 1'b0;
        exc_code_nxt = 2'b00;
        ack_ok       = 1'b0;
        case (state)
            IDLE: begin
                if (access && !reset) begin
                    stall_out = 1'b1;
                    state_nxt = DONE;
                    if (illegal) begin
                        exc_set      = 1'b1;
                        exc_code_nxt = EXC_ILLEGAL;
                    end else if (misaligned) begin
                        exc_set      = 1'b1;
                        exc_code_nxt = EXC_MISALIGN;
                    end else begin
                        start_bus = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                stall_out = 1'b1;
                bus_req   = 1'b1;
                // An ack in the final allowed cycle still completes the access.
                if (bus_ack) begin
                    ack_ok    = 1'b1;
                    state_nxt = DONE;
                end else if (cnt_inc == TIMEOUT_LIM) begin
                    exc_set      = 1'b1;
                    exc_code_nxt = EXC_TIMEOUT;
                    state_nxt    = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= 8'd0;
            offset        <= 2'd0;
            op            <= 3'd0;
            bus_we        <= 1'b0;
            bus_addr      <= 32'd0;
            bus_be        <= 4'd0;
            bus_wdata     <= 32'd0;
            LoadData_out  <= 32'd0;
            LoadValid_out <= 1'b0;
            exc_valid_out <= 1'b0;
            exc_code_out  <= 2'b00;
        end else begin
            LoadValid_out <= 1'b0;
            exc_valid_out <= 1'b0;
            exc_code_out  <= 2'b00;
            LoadData_out  <= 32'd0;

            if (start_bus) begin
                bus_addr  <= {Addr_in[31:2], 2'b00};
                bus_we    <= MemWrite_in;
                bus_be    <= be_nxt;
                bus_wdata <= MemWrite_in ? wdata_nxt : 32'd0;
                offset    <= Addr_in[1:0];
                op        <= MemOp_in;
            end

            if ((state == REQ) && (state_nxt == REQ)) begin
                cnt <= cnt_inc;
            end else begin
                cnt <= 8'd0;
            end

            if (exc_set) begin
                exc_valid_out <= 1'b1;
                exc_code_out  <= exc_code_nxt;
            end

            if (ack_ok && !bus_we) begin
                LoadValid_out <= 1'b1;
                LoadData_out  <= load_ext;
            end
        end
    end

endmodule
